hybrid_branch_predictor: RTL and testbench

Tournament branch predictor feeding the IF-stage PC mux and the IF/ID register (branch_prediction, branch_predicted_target). It combines a bimodal table, a gshare table, a per-PC chooser and a direct-mapped BTB. It predicts combinationally from the current fetch PC. It trains on branch resolution reported by EX.

---
 rtl/hybrid_branch_predictor.sv | 141 ++++++++++++++
 tb/tb_hybrid_branch_predictor.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/hybrid_branch_predictor.sv
// Tournament branch predictor: bimodal + gshare + per-PC chooser + direct-mapped BTB.
// Predicts combinationally from fetch_pc and trains on EX resolution at posedge clk.
module hybrid_branch_predictor #(
    parameter int INDEX_BITS = 6,
    parameter int GHR_BITS   = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_pc,
    input  logic        fetch_valid,
    output logic        branch_prediction,
    output logic [31:0] branch_predicted_target,
    input  logic        update_valid,
    input  logic [31:0] update_pc,
    input  logic        update_taken,
    input  logic [31:0] update_target,
    input  logic        update_mispredict,
    output logic [31:0] perf_mispredicts
);
    localparam int ENTRIES  = 1 << INDEX_BITS;
    localparam int TAG_BITS = 30 - INDEX_BITS;

    // Tables are kept per entry and exposed as flat packed vectors for indexed reads.
    logic [2*ENTRIES-1:0]        bim_flat;
    logic [2*ENTRIES-1:0]        gsh_flat;
    logic [2*ENTRIES-1:0]        cho_flat;
    logic [ENTRIES-1:0]          btb_valid_flat;
    logic [TAG_BITS*ENTRIES-1:0] btb_tag_flat;
    logic [32*ENTRIES-1:0]       btb_target_flat;

    logic [GHR_BITS-1:0] ghr_reg;
    logic [31:0]         perf_reg;

    function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
        if (up) return (c == 2'b11) ? c : c + 2'b01;
        else    return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    // Prediction path
    logic [INDEX_BITS-1:0] f_idx;
    logic [INDEX_BITS-1:0] fg_idx;
    logic [TAG_BITS-1:0]   f_tag;
    logic [1:0]            f_bim;
    logic [1:0]            f_gsh;
    logic [1:0]            f_cho;
    logic                  f_hit;
    logic                  f_dir;

    assign f_idx  = fetch_pc[INDEX_BITS+1:2];
    assign fg_idx = f_idx ^ ghr_reg;
    assign f_tag  = fetch_pc[31:INDEX_BITS+2];
    assign f_bim  = bim_flat[2*f_idx +: 2];
    assign f_gsh  = gsh_flat[2*fg_idx +: 2];
    assign f_cho  = cho_flat[2*f_idx +: 2];
    assign f_hit  = btb_valid_flat[f_idx] && (btb_tag_flat[TAG_BITS*f_idx +: TAG_BITS] == f_tag);
    assign f_dir  = f_cho[1] ? f_gsh[1] : f_bim[1];

    assign branch_prediction       = fetch_valid && f_hit && f_dir;
    assign branch_predicted_target = branch_prediction ? btb_target_flat[32*f_idx +: 32]
                                                       : fetch_pc + 32'd4;
    assign perf_mispredicts        = perf_reg;

    // Training path: all lookups use pre-edge state, including the unshifted ghr.
    logic [INDEX_BITS-1:0] u_idx;
    logic [INDEX_BITS-1:0] ug_idx;
    logic [TAG_BITS-1:0]   u_tag;
    logic [1:0]            u_bim;
    logic [1:0]            u_gsh;
    logic [1:0]            u_cho;
    logic [1:0]            bim_next;
    logic [1:0]            gsh_next;
    logic [1:0]            cho_next;
    logic                  cho_change;

    assign u_idx      = update_pc[INDEX_BITS+1:2];
    assign ug_idx     = u_idx ^ ghr_reg;
    assign u_tag      = update_pc[31:INDEX_BITS+2];
    assign u_bim      = bim_flat[2*u_idx +: 2];
    assign u_gsh      = gsh_flat[2*ug_idx +: 2];
    assign u_cho      = cho_flat[2*u_idx +: 2];
    assign bim_next   = sat_step(u_bim, update_taken);
    assign gsh_next   = sat_step(u_gsh, update_taken);
    assign cho_change = u_bim[1] != u_gsh[1];
    assign cho_next   = sat_step(u_cho, u_gsh[1] == update_taken);

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic [1:0]          bim_reg;
            logic [1:0]          gsh_reg;
            logic [1:0]          cho_reg;
            logic                btb_valid_reg;
            logic [TAG_BITS-1:0] btb_tag_reg;
            logic [31:0]         btb_target_reg;
            logic                sel_u;
            logic                sel_ug;

            assign sel_u  = update_valid && (u_idx == INDEX_BITS'(gi));
            assign sel_ug = update_valid && (ug_idx == INDEX_BITS'(gi));

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    bim_reg        <= 2'b01;
                    gsh_reg        <= 2'b01;
                    cho_reg        <= 2'b01;
                    btb_valid_reg  <= 1'b0;
                    btb_tag_reg    <= '0;
                    btb_target_reg <= '0;
                end else begin
                    if (sel_u) begin
                        bim_reg <= bim_next;
                        if (cho_change) cho_reg <= cho_next;
                        if (update_taken) begin
                            btb_valid_reg  <= 1'b1;
                            btb_tag_reg    <= u_tag;
                            btb_target_reg <= update_target;
                        end
                    end
                    if (sel_ug) gsh_reg <= gsh_next;
                end
            end

            assign bim_flat[2*gi +: 2]                  = bim_reg;
            assign gsh_flat[2*gi +: 2]                  = gsh_reg;
            assign cho_flat[2*gi +: 2]                  = cho_reg;
            assign btb_valid_flat[gi]                   = btb_valid_reg;
            assign btb_tag_flat[TAG_BITS*gi +: TAG_BITS] = btb_tag_reg;
            assign btb_target_flat[32*gi +: 32]         = btb_target_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr_reg  <= '0;
            perf_reg <= '0;
        end else if (update_valid) begin
            ghr_reg <= {ghr_reg[GHR_BITS-2:0], update_taken};
            if (update_mispredict && (perf_reg != 32'hFFFF_FFFF)) perf_reg <= perf_reg + 32'd1;
        end
    end
endmodule

// File: tb/tb_hybrid_branch_predictor.sv
// Scoreboard bench: driver pushes expectations from a table-level reference model,
// monitor compares them against the DUT's combinational outputs each cycle.
module tb_hybrid_branch_predictor;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] fetch_pc = '0;
    logic        fetch_valid = 1'b0;
    logic        branch_prediction;
    logic [31:0] branch_predicted_target;
    logic        update_valid = 1'b0;
    logic [31:0] update_pc = '0;
    logic        update_taken = 1'b0;
    logic [31:0] update_target = '0;
    logic        update_mispredict = 1'b0;
    logic [31:0] perf_mispredicts;

    hybrid_branch_predictor #(.INDEX_BITS(6), .GHR_BITS(6)) dut (
        .clk(clk), .rst(rst),
        .fetch_pc(fetch_pc), .fetch_valid(fetch_valid),
        .branch_prediction(branch_prediction),
        .branch_predicted_target(branch_predicted_target),
        .update_valid(update_valid), .update_pc(update_pc),
        .update_taken(update_taken), .update_target(update_target),
        .update_mispredict(update_mispredict),
        .perf_mispredicts(perf_mispredicts)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pred;
        logic [31:0] tgt;
        logic [31:0] perf;
        logic [31:0] pc;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    // Reference model: counters as plain integers 0..3, history as an integer.
    int          m_bim[64];
    int          m_gsh[64];
    int          m_cho[64];
    bit          m_valid[64];
    int unsigned m_tag[64];
    logic [31:0] m_tgt[64];
    int          m_ghr;
    longint      m_perf;

    function automatic int clamp3(input int v);
        return (v < 0) ? 0 : ((v > 3) ? 3 : v);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 64; k++) begin
            m_bim[k] = 1; m_gsh[k] = 1; m_cho[k] = 1; m_valid[k] = 0;
            m_tag[k] = 0; m_tgt[k] = '0;
        end
        m_ghr  = 0;
        m_perf = 0;
    endtask

    // Drive one cycle at the negedge; expectation reflects state before the coming edge.
    task automatic step(input bit r, input bit fv, input logic [31:0] fpc,
                        input bit uv, input logic [31:0] upc, input bit ut,
                        input logic [31:0] utgt, input bit um);
        exp_t e;
        int i, g, u, ug;
        bit hit, dir, bt, gt;
        @(negedge clk);
        rst = r; fetch_valid = fv; fetch_pc = fpc;
        update_valid = uv; update_pc = upc; update_taken = ut;
        update_target = utgt; update_mispredict = um;
        if (!r) model_reset();
        i   = int'(fpc[7:2]);
        g   = i ^ m_ghr;
        hit = m_valid[i] && (m_tag[i] == (fpc >> 8));
        dir = (m_cho[i] >= 2) ? (m_gsh[g] >= 2) : (m_bim[i] >= 2);
        e.pred = fv && hit && dir;
        e.tgt  = e.pred ? m_tgt[i] : fpc + 32'd4;
        e.perf = 32'(m_perf);
        e.pc   = fpc;
        exp_q.push_back(e);
        if (r && uv) begin
            u  = int'(upc[7:2]);
            ug = u ^ m_ghr;
            bt = m_bim[u] >= 2;
            gt = m_gsh[ug] >= 2;
            if (bt != gt) m_cho[u] = clamp3(m_cho[u] + ((gt == ut) ? 1 : -1));
            m_bim[u]  = clamp3(m_bim[u] + (ut ? 1 : -1));
            m_gsh[ug] = clamp3(m_gsh[ug] + (ut ? 1 : -1));
            if (ut) begin
                m_valid[u] = 1; m_tag[u] = upc >> 8; m_tgt[u] = utgt;
            end
            m_ghr = ((m_ghr << 1) | int'(ut)) & 63;
            if (um && m_perf < 64'hFFFF_FFFF) m_perf++;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                txn++;
                checks++;
                if (branch_prediction !== e.pred || branch_predicted_target !== e.tgt ||
                    perf_mispredicts !== e.perf) begin
                    errors++;
                    $display("FAIL txn %0d pc=%h got pred=%0b tgt=%h perf=%0d want pred=%0b tgt=%h perf=%0d",
                             txn, e.pc, branch_prediction, branch_predicted_target,
                             perf_mispredicts, e.pred, e.tgt, e.perf);
                end else begin
                    $display("txn %0d pc=%h pred=%0b tgt=%h perf=%0d ok",
                             txn, e.pc, e.pred, e.tgt, e.perf);
                end
            end
        end
    end

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        p = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
        if ($urandom_range(0, 15) == 0) p = p | 32'hFFFF_FF00;
        return p;
    endfunction

    initial begin : driver
        model_reset();
        // Held in reset, including the wrap-around target.
        step(0, 1, 32'h100, 0, 0, 0, 0, 0);
        step(0, 1, 32'hFFFF_FFFC, 1, 32'h100, 1, 32'h80, 1);
        // Same-cycle fetch and taken update: old state predicts, then the new one.
        step(1, 1, 32'h100, 1, 32'h100, 1, 32'h80, 0);
        step(1, 1, 32'h100, 0, 0, 0, 0, 0);
        step(1, 0, 32'h100, 0, 0, 0, 0, 0);
        step(1, 1, 32'h200, 0, 0, 0, 0, 0);
        step(1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
        // Disagreeing tables with gshare correct, then re-check the BTB entry survives.
        step(1, 1, 32'h100, 1, 32'h100, 0, 32'h999, 1);
        step(1, 1, 32'h100, 0, 0, 0, 0, 0);
        step(1, 1, 32'h103, 0, 0, 0, 0, 0);
        // Saturation towards zero on a never-taken branch.
        for (int k = 0; k < 5; k++) step(1, 1, 32'h40, 1, 32'h40, 0, 32'h4, 1);
        step(1, 1, 32'h40, 0, 0, 0, 0, 0);
        // Saturation towards strongly taken with aliasing tag traffic.
        for (int k = 0; k < 6; k++) step(1, 1, 32'h1C4, 1, 32'h1C4, 1, 32'h1234_5678, 0);
        step(1, 1, 32'h0C4, 1, 32'h0C4, 1, 32'hABCD_0000, 0);
        step(1, 1, 32'h1C4, 0, 0, 0, 0, 0);
        step(1, 1, 32'h0C4, 0, 0, 0, 0, 0);
        // Randomised traffic; fetches often reuse the last update PC to hit the BTB.
        for (int k = 0; k < 400; k++) begin
            logic [31:0] upc, fpc;
            upc = rand_pc();
            fpc = ($urandom_range(0, 1) == 1) ? upc : rand_pc();
            step(1, $urandom_range(0, 7) != 0, fpc,
                 $urandom_range(0, 3) != 0, upc, $urandom_range(0, 2) != 0,
                 $urandom, $urandom_range(0, 1) == 1);
        end
        // Asynchronous reset between edges while an update is presented.
        step(1, 1, 32'h100, 1, 32'h100, 1, 32'h80, 1);
        step(1, 1, 32'h100, 1, 32'h100, 1, 32'h80, 1);
        step(0, 1, 32'h100, 1, 32'h100, 1, 32'h80, 1);
        step(1, 1, 32'h100, 0, 0, 0, 0, 0);
        step(1, 1, 32'h100, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain queue left=%0d want=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
